// File: rtl/nand3_chk_pkg.sv
// Shared types and helpers for the NAND3 exhaustive vector checker.
// The state encoding, vector count and expected-response function live here.
package nand3_chk_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SETTLE,
    SAMPLE,
    DONE
  } state_t;

  localparam int NUM_VEC = 8;

  function automatic logic nand3_exp(input logic [2:0] v);
    return ~&v;
  endfunction

endpackage

// File: rtl/nand3_settle_tmr.sv
// Settle-window timer: counts held cycles of the current vector and flags
// the last one so the checker knows when to sample the gate output.
module nand3_settle_tmr #(
  parameter int SETTLE_CYC = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic expire
);

  localparam int TW = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;

  logic [TW-1:0] cnt;

  assign expire = (cnt == TW'(SETTLE_CYC - 1));

  // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n || clr) begin
      cnt <= '0;
    end else if (en && !expire) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/nand3_vec_chk.sv
// Exhaustive stimulus generator and response checker for a 3-input NAND stage:
// walks all 8 input vectors, samples out2 after a settle window and scores it.
module nand3_vec_chk
  import nand3_chk_pkg::*;
#(
  parameter int SETTLE_CYC = 2,
  parameter int ERR_W      = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             out2,
  output logic             in1,
  output logic             in2,
  output logic             in3,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [ERR_W-1:0] err_cnt,
  output logic [2:0]       fail_vec,
  output logic             fail_valid
);

  localparam logic [ERR_W-1:0] ERR_MAX = '1;
  localparam logic [2:0]       LAST_VEC = 3'(NUM_VEC - 1);

  state_t     state, state_nxt;
  logic [2:0] vec;
  logic       tmr_expire;
  logic       mismatch;

  nand3_settle_tmr #(
    .SETTLE_CYC(SETTLE_CYC)
  ) u_tmr (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (state != SETTLE),
    .en    (state == SETTLE),
    .expire(tmr_expire)
  );

  // Case-inequality so an x or z response is scored as a failure.
  assign mismatch = (out2 !== nand3_exp(vec));

  assign {in3, in2, in1} = (state == IDLE) ? 3'b000 : vec;

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // NOTE: next-state is assigned a default first so no path leaves it unassigned (no latch).
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = SETTLE;
      SETTLE:  if (tmr_expire) state_nxt = SAMPLE;
      SAMPLE:  state_nxt = (vec == LAST_VEC) ? DONE : SETTLE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vec        <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      pass       <= 1'b0;
      err_cnt    <= '0;
      fail_vec   <= '0;
      fail_valid <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            vec        <= '0;
            err_cnt    <= '0;
            fail_vec   <= '0;
            fail_valid <= 1'b0;
            pass       <= 1'b0;
            busy       <= 1'b1;
          end
        end
        SAMPLE: begin
          if (mismatch) begin
            if (err_cnt != ERR_MAX) err_cnt <= err_cnt + 1'b1;
            if (!fail_valid) begin
              fail_vec   <= vec;
              fail_valid <= 1'b1;
            end
          end
          if (vec != LAST_VEC) vec <= vec + 1'b1;
        end
        DONE: begin
          // err_cnt already carries the final SAMPLE's update here.
          done <= 1'b1;
          pass <= (err_cnt == '0);
          busy <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_nand3_vec_chk.sv
// Self-checking bench: two checker instances (default and SETTLE_CYC=1/ERR_W=2)
// each drive an emulated NAND3 whose response is corrupted on selected vectors.
module tb_nand3_vec_chk;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic       start_a = 1'b0, start_b = 1'b0;
  logic [7:0] mask_a = '0, mask_b = '0;

  logic       in1_a, in2_a, in3_a, busy_a, done_a, pass_a, fvld_a, out2_a;
  logic [3:0] err_a;
  logic [2:0] fvec_a;
  logic       in1_b, in2_b, in3_b, busy_b, done_b, pass_b, fvld_b, out2_b;
  logic [1:0] err_b;
  logic [2:0] fvec_b;

  // Emulated gate: correct NAND unless the mask marks that input vector as faulty.
  assign out2_a = ~(in1_a & in2_a & in3_a) ^ mask_a[{in3_a, in2_a, in1_a}];
  assign out2_b = ~(in1_b & in2_b & in3_b) ^ mask_b[{in3_b, in2_b, in1_b}];

  nand3_vec_chk dut_a (
    .clk(clk), .rst_n(rst_n), .start(start_a), .out2(out2_a),
    .in1(in1_a), .in2(in2_a), .in3(in3_a), .busy(busy_a), .done(done_a),
    .pass(pass_a), .err_cnt(err_a), .fail_vec(fvec_a), .fail_valid(fvld_a)
  );

  nand3_vec_chk #(.SETTLE_CYC(1), .ERR_W(2)) dut_b (
    .clk(clk), .rst_n(rst_n), .start(start_b), .out2(out2_b),
    .in1(in1_b), .in2(in2_b), .in3(in3_b), .busy(busy_b), .done(done_b),
    .pass(pass_b), .err_cnt(err_b), .fail_vec(fvec_b), .fail_valid(fvld_b)
  );

  typedef struct packed {
    logic [2:0] vin;
    logic       busy;
    logic       done;
    logic       pass;
    logic [3:0] err;
    logic [2:0] fvec;
    logic       fvld;
  } obs_t;

  typedef struct {
    int         err;
    logic [2:0] fvec;
    logic       fvld;
    logic       pass;
  } exp_t;

  typedef struct {
    int         sel;
    logic [7:0] mask;
    exp_t       e;
  } vec_t;

  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic obs_t get_obs(input int sel);
    obs_t o;
    if (sel == 0) begin
      o.vin = {in3_a, in2_a, in1_a}; o.busy = busy_a; o.done = done_a; o.pass = pass_a;
      o.err = err_a; o.fvec = fvec_a; o.fvld = fvld_a;
    end else begin
      o.vin = {in3_b, in2_b, in1_b}; o.busy = busy_b; o.done = done_b; o.pass = pass_b;
      o.err = {2'b00, err_b}; o.fvec = fvec_b; o.fvld = fvld_b;
    end
    return o;
  endfunction

  // Reference: count faulty vectors (saturating), first faulty one in ascending order.
  function automatic exp_t model(input logic [7:0] mask, input int sel);
    exp_t e;
    int   n = 0;
    int   errmax = (sel == 0) ? 15 : 3;
    e.fvld = 1'b0;
    e.fvec = 3'd0;
    for (int v = 0; v < 8; v++) begin
      if (mask[v]) begin
        n++;
        if (!e.fvld) begin
          e.fvld = 1'b1;
          e.fvec = 3'(v);
        end
      end
    end
    e.err  = (n > errmax) ? errmax : n;
    e.pass = (mask == 8'h00);
    return e;
  endfunction

  task automatic set_start(input int sel, input logic v);
    if (sel == 0) start_a = v; else start_b = v;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_run(input int sel, input logic [7:0] mask, input bit repulse, input string tag);
    int   per;
    int   cnt;
    int   done_at;
    bit   seq_ok;
    obs_t o;
    per = (sel == 0) ? 3 : 2;
    cnt = 0;
    done_at = -1;
    seq_ok = 1'b1;
    if (sel == 0) mask_a = mask; else mask_b = mask;
    set_start(sel, 1'b1);
    tick();
    set_start(sel, 1'b0);
    while (done_at < 0 && cnt < 200) begin
      o = get_obs(sel);
      if (o.done) done_at = cnt;
      else if (cnt < 8 * per && (o.vin != 3'(cnt / per) || !o.busy)) seq_ok = 1'b0;
      if (done_at < 0) begin
        if (repulse) set_start(sel, (cnt == 4) || (cnt == 9));
        tick();
        cnt++;
      end
    end
    set_start(sel, 1'b0);
    check({tag, " done_latency"}, done_at, 8 * per + 1);
    check({tag, " vec_seq_busy"}, seq_ok, 1'b1);
    o = get_obs(sel);
    check({tag, " busy_at_done"}, o.busy, 1'b0);
    tick();
    o = get_obs(sel);
    check({tag, " done_pulse_width"}, {o.done, o.busy}, 2'b00);
  endtask

  task automatic check_result(input int sel, input exp_t e, input string tag);
    obs_t o;
    o = get_obs(sel);
    check({tag, " err_cnt"}, o.err, e.err);
    check({tag, " fail_vec"}, o.fvec, e.fvec);
    check({tag, " fail_valid"}, o.fvld, e.fvld);
    check({tag, " pass"}, o.pass, e.pass);
  endtask

  vec_t tbl[8];

  initial begin
    obs_t o;
    bit   saw_done;
    int   n;
    logic [7:0] m;
    int   s;

    tbl[0] = '{0, 8'h00, '{0, 3'd0, 1'b0, 1'b1}};  // good gate
    tbl[1] = '{0, 8'h80, '{1, 3'd7, 1'b1, 1'b0}};  // out2 stuck at 1
    tbl[2] = '{0, 8'h01, '{1, 3'd0, 1'b1, 1'b0}};
    tbl[3] = '{0, 8'hFF, '{8, 3'd0, 1'b1, 1'b0}};
    tbl[4] = '{0, 8'h0C, '{2, 3'd2, 1'b1, 1'b0}};
    tbl[5] = '{1, 8'h7F, '{3, 3'd0, 1'b1, 1'b0}};  // out2 stuck at 0, counter saturates
    tbl[6] = '{1, 8'h00, '{0, 3'd0, 1'b0, 1'b1}};
    tbl[7] = '{1, 8'hF0, '{3, 3'd4, 1'b1, 1'b0}};

    repeat (3) tick();
    check("reset_state_a", get_obs(0), '0);
    check("reset_state_b", get_obs(1), '0);
    rst_n = 1'b1;
    tick();

    for (int i = 0; i < 8; i++) begin
      do_run(tbl[i].sel, tbl[i].mask, 1'b0, $sformatf("tbl%0d", i));
      check_result(tbl[i].sel, tbl[i].e, $sformatf("tbl%0d", i));
    end

    for (int i = 0; i < 16; i++) begin
      s = int'($urandom_range(0, 1));
      m = 8'($urandom);
      do_run(s, m, 1'b0, $sformatf("rnd%0d", i));
      check_result(s, model(m, s), $sformatf("rnd%0d m=%02h", i, m));
    end

    // start re-pulsed mid-run must not restart or disturb the scoring
    do_run(0, 8'h22, 1'b1, "repulse");
    check_result(0, model(8'h22, 0), "repulse");

    // reset while vector 4 is applied aborts the run with no done pulse
    mask_a = 8'h03;
    start_a = 1'b1;
    tick();
    start_a = 1'b0;
    repeat (12) tick();
    o = get_obs(0);
    check("midrst_pre_vec", o.vin, 3'd4);
    check("midrst_pre_err", o.err, 4'd2);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check("midrst_outputs", get_obs(0), '0);
    saw_done = 1'b0;
    for (int i = 0; i < 30; i++) begin
      tick();
      if (done_a || busy_a) saw_done = 1'b1;
    end
    check("midrst_no_done", saw_done, 1'b0);
    do_run(0, 8'h00, 1'b0, "after_rst");
    check_result(0, model(8'h00, 0), "after_rst");

    // start held high through DONE restarts on the following edge
    mask_a = 8'h00;
    start_a = 1'b1;
    n = 0;
    while (!done_a && n < 100) begin
      tick();
      n++;
    end
    check("held_first_done", done_a, 1'b1);
    tick();
    check("held_restart", {busy_a, done_a}, 2'b10);
    start_a = 1'b0;
    n = 0;
    while (!done_a && n < 100) begin
      tick();
      n++;
    end
    check("held_second_latency", n, 25);
    check("held_second_pass", pass_a, 1'b1);
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
